// File: rtl/sn_stream_gen_if.sv
// Stream-generator handshake bundle: start/lane values/hold in, stream bits and status out.
interface sn_stream_gen_if #(
  parameter int NUM_BIT = 4,
  parameter int DIM     = 4
);
  logic                             i_start_sng;
  logic [DIM-1:0][NUM_BIT-1:0]      i_x_sng;
  logic                             i_hold_sng;
  logic                             o_valid_sng;
  logic [DIM-1:0]                   o_sn_bit_sng;
  logic                             o_busy_sng;
  logic                             o_done_sng;

  modport master (
    output i_start_sng, i_x_sng, i_hold_sng,
    input  o_valid_sng, o_sn_bit_sng, o_busy_sng, o_done_sng
  );

  modport slave (
    input  i_start_sng, i_x_sng, i_hold_sng,
    output o_valid_sng, o_sn_bit_sng, o_busy_sng, o_done_sng
  );
endinterface

// File: rtl/sn_stream_gen.sv
// Binary-to-stochastic encoder: one unipolar bitstream per lane, thresholded
// against a shared maximal-length LFSR that sweeps 1..2^NUM_BIT-1 once per stream.
module sn_stream_gen #(
  parameter int                 NUM_BIT = 4,
  parameter int                 DIM     = 4,
  parameter logic [NUM_BIT-1:0] TAPS    = 4'b1100,
  parameter logic [NUM_BIT-1:0] SEED    = 4'b0001
) (
  input  logic             i_clk_sng,
  input  logic             i_rst_n_sng,
  sn_stream_gen_if.slave   sng
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Count of the final beat: 2^NUM_BIT-2.
  localparam logic [NUM_BIT-1:0] LAST_BEAT = {{(NUM_BIT-1){1'b1}}, 1'b0};

  state_t                      state_r, state_nxt;
  logic [DIM-1:0][NUM_BIT-1:0] x_r;
  logic [NUM_BIT-1:0]          lfsr_r;
  logic [NUM_BIT-1:0]          cnt_r;
  logic                        start_ok;
  logic                        beat;
  logic [DIM-1:0]              cmp;

  always_ff @(posedge i_clk_sng or negedge i_rst_n_sng) begin
    if (!i_rst_n_sng) state_r <= IDLE;
    else              state_r <= state_nxt;
  end

  always_comb begin
    state_nxt        = state_r;
    start_ok         = 1'b0;
    beat             = 1'b0;
    sng.o_valid_sng  = 1'b0;
    sng.o_busy_sng   = 1'b0;
    sng.o_done_sng   = 1'b0;
    unique case (state_r)
      IDLE: begin
        if (sng.i_start_sng) begin
          start_ok  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        sng.o_busy_sng  = 1'b1;
        beat            = !sng.i_hold_sng;
        sng.o_valid_sng = beat;
        if (beat && cnt_r == LAST_BEAT) state_nxt = DONE;
      end
      DONE: begin
        sng.o_done_sng = 1'b1;
        if (sng.i_start_sng) begin
          start_ok  = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmp = '0;
    for (int unsigned i = 0; i < DIM; i++) cmp[i] = (x_r[i] >= lfsr_r);
  end

  assign sng.o_sn_bit_sng = sng.o_valid_sng ? cmp : '0;

  // LFSR and beat counter advance only on emitted beats, so hold freezes both.
  always_ff @(posedge i_clk_sng or negedge i_rst_n_sng) begin
    if (!i_rst_n_sng) begin
      x_r    <= '0;
      lfsr_r <= SEED;
      cnt_r  <= '0;
    end else if (start_ok) begin
      x_r    <= sng.i_x_sng;
      lfsr_r <= SEED;
      cnt_r  <= '0;
    end else if (beat) begin
      lfsr_r <= {lfsr_r[NUM_BIT-2:0], ^(lfsr_r & TAPS)};
      cnt_r  <= cnt_r + 1'b1;
    end
  end

endmodule

// File: tb/tb_sn_stream_gen.sv
// Self-checking bench for sn_stream_gen: table-driven streams, reset/back-to-back
// sequences, and randomized vectors with random hold against a ones-count model.
module tb_sn_stream_gen;

  localparam int NUM_BIT = 4;
  localparam int DIM     = 4;
  localparam int L       = (1 << NUM_BIT) - 1;
  localparam int SEEDV   = 1;

  typedef logic [DIM-1:0][NUM_BIT-1:0] xvec_t;

  typedef struct {
    int x [DIM];
    int h_at1, h_len1, h_at2, h_len2;
    bit start_in_run;
    bit b2b;
    int exp_done;
  } vec_t;

  logic i_clk_udc;
  logic i_rst_udc;

  int n_chk  = 0;
  int n_fail = 0;

  sn_stream_gen_if #(.NUM_BIT(NUM_BIT), .DIM(DIM)) bus ();

  sn_stream_gen #(
    .NUM_BIT (NUM_BIT),
    .DIM     (DIM),
    .TAPS    (4'b1100),
    .SEED    (4'b0001)
  ) dut (
    .i_clk_sng   (i_clk_udc),
    .i_rst_n_sng (i_rst_udc),
    .sng         (bus.slave)
  );

  initial i_clk_udc = 1'b0;
  always #5 i_clk_udc = ~i_clk_udc;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ones over one stream: thresholds 1..L each appear once, lane bit = (x >= t).
  function automatic int exp_ones(input int x);
    int n = 0;
    for (int t = 1; t <= L; t++) if (x >= t) n++;
    return n;
  endfunction

  function automatic xvec_t pack_x(input int x [DIM]);
    xvec_t v;
    for (int i = 0; i < DIM; i++) v[i] = NUM_BIT'(x[i]);
    return v;
  endfunction

  // Runs one stream. chain=1: start was already driven during the previous DONE cycle.
  task automatic run_stream(input xvec_t xin, input int h_at1, input int h_len1,
                            input int h_at2, input int h_len2, input bit rnd_hold,
                            input bit start_in_run, input bit chain,
                            input bit b2b, input xvec_t xnext, input int exp_done);
    int beats = 0, holds = 0, first_valid = -1, first_nohold = -1, done_cyc = -1;
    int viol = 0, r1 = h_len1, r2 = h_len2, busy_at_done = -1;
    int ones [DIM];
    logic [DIM-1:0] first_bits = '0, exp_first;
    bit sir_done = 1'b0;
    bit h;
    for (int i = 0; i < DIM; i++) ones[i] = 0;
    if (!chain) begin
      @(negedge i_clk_udc);
      bus.i_x_sng     = xin;
      bus.i_start_sng = 1'b1;
    end
    @(posedge i_clk_udc);
    #1;
    bus.i_start_sng = 1'b0;
    bus.i_x_sng     = ~xin;
    chk("busy_after_start", bus.o_busy_sng, 1);
    for (int c = 1; c <= 80 && done_cyc < 0; c++) begin
      if (c > 1) begin
        @(posedge i_clk_udc);
        #1;
      end
      h = 1'b0;
      if (rnd_hold) h = ($urandom_range(0, 3) == 0);
      else if (beats == h_at1 && r1 > 0) begin h = 1'b1; r1--; end
      else if (beats == h_at2 && r2 > 0) begin h = 1'b1; r2--; end
      bus.i_start_sng = 1'b0;
      if (start_in_run && !sir_done && beats == 7) begin
        bus.i_start_sng = 1'b1;
        bus.i_x_sng     = {DIM{4'd9}};
        sir_done        = 1'b1;
      end
      bus.i_hold_sng = h;
      if (h && beats < L) holds++;
      if (!h && first_nohold < 0) first_nohold = c;
      #1;
      if (bus.o_valid_sng) begin
        if (first_valid < 0) begin
          first_valid = c;
          first_bits  = bus.o_sn_bit_sng;
        end
        for (int i = 0; i < DIM; i++) ones[i] += int'(bus.o_sn_bit_sng[i]);
        beats++;
      end else if (bus.o_sn_bit_sng != '0) viol++;
      if (h && bus.o_valid_sng) viol++;
      if (bus.o_done_sng) begin
        done_cyc     = c;
        busy_at_done = int'(bus.o_busy_sng);
        if (b2b) begin
          bus.i_x_sng     = xnext;
          bus.i_start_sng = 1'b1;
        end
      end
    end
    bus.i_hold_sng = 1'b0;
    if (!b2b) bus.i_start_sng = 1'b0;
    for (int i = 0; i < DIM; i++) exp_first[i] = (int'(xin[i]) >= SEEDV);
    chk("valid_beats", beats, L);
    for (int i = 0; i < DIM; i++) chk($sformatf("ones_lane%0d", i), ones[i], exp_ones(int'(xin[i])));
    chk("done_cycle_model", done_cyc, L + 1 + holds);
    if (exp_done >= 0) chk("done_cycle_table", done_cyc, exp_done);
    chk("first_valid_cycle", first_valid, first_nohold);
    chk("first_bits_vs_seed", first_bits, exp_first);
    chk("hold_gating_violations", viol, 0);
    chk("busy_in_done", busy_at_done, 0);
    if (!b2b) begin
      @(posedge i_clk_udc);
      #2;
      chk("done_one_cycle", {bus.o_done_sng, bus.o_busy_sng, bus.o_valid_sng}, 0);
    end
  endtask

  vec_t tbl [4];

  initial begin
    int beats;
    int bad;
    int xr [DIM];
    xvec_t xv;
    tbl[0] = '{x:'{0, 1, 7, 15}, h_at1:0, h_len1:0, h_at2:0, h_len2:0, start_in_run:0, b2b:0, exp_done:16};
    tbl[1] = '{x:'{5, 10, 2, 12}, h_at1:4, h_len1:3, h_at2:14, h_len2:1, start_in_run:0, b2b:0, exp_done:20};
    tbl[2] = '{x:'{1, 14, 6, 3}, h_at1:0, h_len1:0, h_at2:0, h_len2:0, start_in_run:1, b2b:1, exp_done:16};
    tbl[3] = '{x:'{15, 0, 8, 4}, h_at1:0, h_len1:0, h_at2:0, h_len2:0, start_in_run:0, b2b:0, exp_done:16};

    i_rst_udc       = 1'b0;
    bus.i_start_sng = 1'b0;
    bus.i_hold_sng  = 1'b0;
    bus.i_x_sng     = '0;
    repeat (3) @(negedge i_clk_udc);
    chk("reset_valid", bus.o_valid_sng, 0);
    chk("reset_bits", bus.o_sn_bit_sng, 0);
    chk("reset_busy", bus.o_busy_sng, 0);
    chk("reset_done", bus.o_done_sng, 0);
    i_rst_udc = 1'b1;

    for (int v = 0; v < 4; v++) begin
      xv = (v < 3) ? pack_x(tbl[v+1].x) : '0;
      run_stream(pack_x(tbl[v].x), tbl[v].h_at1, tbl[v].h_len1, tbl[v].h_at2,
                 tbl[v].h_len2, 1'b0, tbl[v].start_in_run,
                 (v > 0) && tbl[v-1].b2b, tbl[v].b2b, xv, tbl[v].exp_done);
    end

    // Mid-stream reset at beat 7, then a fresh stream.
    @(negedge i_clk_udc);
    bus.i_x_sng     = pack_x('{0, 1, 7, 15});
    bus.i_start_sng = 1'b1;
    @(negedge i_clk_udc);
    bus.i_start_sng = 1'b0;
    beats = 0;
    for (int c = 0; c < 40 && beats < 7; c++) begin
      if (bus.o_valid_sng) beats++;
      if (beats < 7) @(negedge i_clk_udc);
    end
    chk("reached_beat7", beats, 7);
    #1 i_rst_udc = 1'b0;
    #1;
    chk("rst_async_outputs", {bus.o_valid_sng, bus.o_sn_bit_sng, bus.o_busy_sng, bus.o_done_sng}, 0);
    bad = 0;
    repeat (3) begin
      @(negedge i_clk_udc);
      if (bus.o_done_sng || bus.o_busy_sng || bus.o_valid_sng) bad++;
    end
    i_rst_udc = 1'b1;
    repeat (2) begin
      @(negedge i_clk_udc);
      if (bus.o_done_sng || bus.o_busy_sng || bus.o_valid_sng) bad++;
    end
    chk("rst_no_done_pulse", bad, 0);
    run_stream(pack_x('{3, 0, 15, 8}), 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 16);

    for (int n = 0; n < 32; n++) begin
      for (int i = 0; i < DIM; i++) xr[i] = int'($urandom_range(0, L));
      run_stream(pack_x(xr), 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, '0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
